// File: rtl/banked_mem.sv
// Four-bank, word-interleaved 16-bit memory model with per-bank occupancy
// counters and a fixed two-stage read pipeline.
module banked_mem #(
  parameter int unsigned BANK_BUSY  = 4,
  parameter int unsigned WORDS_LOG2 = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        data_valid,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  logic [1:0]            bank;
  logic [WORDS_LOG2-1:0] row;
  logic                  req;
  logic                  accept;

  logic [15:0] mem [4][1 << WORDS_LOG2];

  logic [2:0]  cnt_d [4];
  logic [2:0]  cnt_q [4];
  logic        s1_valid_d, s1_valid_q;
  logic [15:0] s1_data_d,  s1_data_q;
  logic        out_valid_d, out_valid_q;
  logic [15:0] out_data_d,  out_data_q;

  assign bank = Addr[2:1];
  assign row  = Addr[WORDS_LOG2+2:3];

  // err outranks stall, so a malformed request to a busy bank reports only err
  always_comb begin
    req    = Rd | Wr;
    err    = req & ((Rd & Wr) | Addr[0]);
    stall  = req & ~err & busy[bank];
    accept = req & ~err & ~busy[bank];
  end

  always_comb begin
    for (int unsigned b = 0; b < 4; b++) begin
      busy[b] = (cnt_q[b] != '0);
      if (accept && (bank == 2'(b)))
        cnt_d[b] = 3'(BANK_BUSY - 1);
      else if (cnt_q[b] != '0)
        cnt_d[b] = cnt_q[b] - 3'd1;
      else
        cnt_d[b] = cnt_q[b];
    end
  end

  always_comb begin
    s1_valid_d  = accept & Rd;
    s1_data_d   = s1_valid_d ? mem[bank][row] : '0;
    out_valid_d = s1_valid_q;
    out_data_d  = s1_valid_q ? s1_data_q : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '{default: '0};
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Array storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (accept && Wr)
      mem[bank][row] <= DataIn;
  end

  assign DataOut    = out_data_q;
  assign data_valid = out_valid_q;

endmodule

// File: tb/tb_banked_mem.sv
// Directed bench for banked_mem: per-cycle vector table plus hand-written
// reset, read-after-write and reset-during-read sequences.
module tb_banked_mem;

  logic        clk;
  logic        rst;
  logic        Rd;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        data_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int total;
  int bad;

  banked_mem #(.BANK_BUSY(4), .WORDS_LOG2(13)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rd         (Rd),
    .Wr         (Wr),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .data_valid (data_valid),
    .stall      (stall),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        stall;
    logic        err;
    logic        valid;
    logic [15:0] dout;
    logic [3:0]  busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rd, logic wr, logic [15:0] addr, logic [15:0] din,
                              logic st, logic er, logic vl, logic [15:0] dout,
                              logic [3:0] bz);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
    v.stall = st; v.err = er; v.valid = vl; v.dout = dout; v.busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] din);
    @(posedge clk);
    #1;
    Rd = rd; Wr = wr; Addr = addr; DataIn = din;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;

    // cycle-by-cycle vectors: line write/read, bank conflict, illegal requests
    tv.push_back(mk(0,1,16'h0A40,16'h1111, 0,0,0,16'h0000,4'b0000));
    tv.push_back(mk(0,1,16'h0A42,16'h2222, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(0,1,16'h0A44,16'h3333, 0,0,0,16'h0000,4'b0011));
    tv.push_back(mk(0,1,16'h0A46,16'h4444, 0,0,0,16'h0000,4'b0111));
    tv.push_back(mk(1,0,16'h0A40,16'h0000, 0,0,0,16'h0000,4'b1110));
    tv.push_back(mk(1,0,16'h0A42,16'h0000, 0,0,0,16'h0000,4'b1101));
    tv.push_back(mk(1,0,16'h0A44,16'h0000, 0,0,1,16'h1111,4'b1011));
    tv.push_back(mk(1,0,16'h0A46,16'h0000, 0,0,1,16'h2222,4'b0111));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,1,16'h3333,4'b1110));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,1,16'h4444,4'b1100));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b1000));
    tv.push_back(mk(0,1,16'h0010,16'hAAAA, 0,0,0,16'h0000,4'b0000));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(0,1,16'h0018,16'h5555, 0,0,0,16'h0000,4'b0000));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(1,0,16'h0010,16'h0000, 0,0,0,16'h0000,4'b0000));
    tv.push_back(mk(1,0,16'h0018,16'h0000, 1,0,0,16'h0000,4'b0001));
    tv.push_back(mk(1,0,16'h0018,16'h0000, 1,0,1,16'hAAAA,4'b0001));
    tv.push_back(mk(1,0,16'h0018,16'h0000, 1,0,0,16'h0000,4'b0001));
    tv.push_back(mk(1,0,16'h0018,16'h0000, 0,0,0,16'h0000,4'b0000));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,1,16'h5555,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0000));
    tv.push_back(mk(1,1,16'h0010,16'h1234, 0,1,0,16'h0000,4'b0000));
    tv.push_back(mk(1,0,16'h0003,16'h0000, 0,1,0,16'h0000,4'b0000));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0000));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0000));
    tv.push_back(mk(1,0,16'h0010,16'h0000, 0,0,0,16'h0000,4'b0000));
    tv.push_back(mk(1,0,16'h0011,16'h0000, 0,1,0,16'h0000,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,1,16'hAAAA,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0001));
    tv.push_back(mk(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,4'b0000));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  {12'h0, busy},       16'h0000);
    chk("rst_dout",  DataOut,             16'h0000);
    chk("rst_valid", {15'h0, data_valid}, 16'h0000);
    chk("rst_stall", {15'h0, stall},      16'h0000);
    chk("rst_err",   {15'h0, err},        16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_busy", i),  {12'h0, busy},       16'h0000);
      chk($sformatf("idle%0d_valid", i), {15'h0, data_valid}, 16'h0000);
      chk($sformatf("idle%0d_dout", i),  DataOut,             16'h0000);
      if (i < 2) @(posedge clk);
    end

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].din);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), {15'h0, stall},      {15'h0, tv[i].stall});
      chk($sformatf("v%0d_err", i),   {15'h0, err},        {15'h0, tv[i].err});
      chk($sformatf("v%0d_valid", i), {15'h0, data_valid}, {15'h0, tv[i].valid});
      chk($sformatf("v%0d_dout", i),  DataOut,             tv[i].dout);
      chk($sformatf("v%0d_busy", i),  {12'h0, busy},       {12'h0, tv[i].busy});
    end

    // read-after-write: write at 0, read at 4, data at 6
    drive(1'b0, 1'b1, 16'h0100, 16'hBEEF);
    repeat (3) idle();
    drive(1'b1, 1'b0, 16'h0100, 16'h0000);
    @(negedge clk);
    chk("raw_accept_stall", {15'h0, stall}, 16'h0000);
    idle();
    @(negedge clk);
    chk("raw_t5_valid", {15'h0, data_valid}, 16'h0000);
    idle();
    @(negedge clk);
    chk("raw_valid", {15'h0, data_valid}, 16'h0001);
    chk("raw_dout",  DataOut,             16'hBEEF);
    idle();
    @(negedge clk);
    chk("raw_t7_valid", {15'h0, data_valid}, 16'h0000);
    repeat (3) idle();

    // reset pulsed while a read is in flight
    drive(1'b1, 1'b0, 16'h0100, 16'h0000);
    @(posedge clk);
    #1;
    Rd = 1'b0; Addr = '0;
    rst = 1'b0;
    #3 rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", {12'h0, busy}, 16'h0000);
    idle();
    @(negedge clk);
    chk("rstmid_valid", {15'h0, data_valid}, 16'h0000);
    chk("rstmid_dout",  DataOut,             16'h0000);
    idle();
    @(negedge clk);
    chk("rstmid_valid2", {15'h0, data_valid}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
